// File: rtl/inst_rom_arbiter_pkg.sv
// rtl/inst_rom_arbiter_pkg.sv - shared constants and FSM encoding for the instruction ROM arbiter
package inst_rom_arbiter_pkg;

    localparam logic        CHIP_ENABLE       = 1'b1;
    localparam logic        CHIP_DISABLE      = 1'b0;
    localparam logic [31:0] ZERO_WORD         = 32'h0000_0000;
    localparam int          INST_ADDR_BUS     = 32;
    localparam int          INST_BUS          = 32;
    localparam int          INST_MEM_NUM_LOG2 = 17;
    localparam int          ARB_STARVE_LIMIT  = 4;

    typedef enum logic {
        ARB_IF_PRI    = 1'b0,
        ARB_DBG_FORCE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/inst_rom_arbiter_if.sv
// rtl/inst_rom_arbiter_if.sv - requester, response and ROM signals bundled for the arbiter
interface inst_rom_arbiter_if #(
    parameter int ADDR_W = inst_rom_arbiter_pkg::INST_ADDR_BUS,
    parameter int DATA_W = inst_rom_arbiter_pkg::INST_BUS
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_gnt;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_inst;
    logic              if_rsp_err;

    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic              dbg_rsp_valid;
    logic [DATA_W-1:0] dbg_rsp_inst;
    logic              dbg_rsp_err;

    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_inst;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, if_flush, dbg_req, dbg_addr, rom_inst,
        output if_gnt, if_rsp_valid, if_rsp_inst, if_rsp_err,
        output dbg_gnt, dbg_rsp_valid, dbg_rsp_inst, dbg_rsp_err,
        output rom_ce, rom_addr
    );

    // Requesters plus ROM side
    modport master (
        output if_req, if_addr, if_flush, dbg_req, dbg_addr, rom_inst,
        input  if_gnt, if_rsp_valid, if_rsp_inst, if_rsp_err,
        input  dbg_gnt, dbg_rsp_valid, dbg_rsp_inst, dbg_rsp_err,
        input  rom_ce, rom_addr
    );

endinterface

// File: rtl/inst_addr_check.sv
// rtl/inst_addr_check.sv - combinational word-alignment and ROM range check
module inst_addr_check #(
    parameter int ADDR_W   = 32,
    parameter int MEM_LOG2 = 17
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              err_o
);

    // First illegal byte address, one bit wider so it cannot overflow
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4) << MEM_LOG2;

    assign err_o = (addr_i[1:0] != 2'b00) || ({1'b0, addr_i} >= ADDR_LIMIT);

endmodule

// File: rtl/inst_rom_arbiter.sv
// rtl/inst_rom_arbiter.sv - IF/DBG arbiter for the instruction ROM; INST_ROM_ARBITER_PERF_EN adds grant/conflict counters
module inst_rom_arbiter
    import inst_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W       = INST_ADDR_BUS,
    parameter int DATA_W       = INST_BUS,
    parameter int MEM_LOG2     = INST_MEM_NUM_LOG2,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic                clk,
    input  logic                rst,
    inst_rom_arbiter_if.slave   bus
`ifdef INST_ROM_ARBITER_PERF_EN
    ,
    output logic [31:0]         perf_if_cnt,
    output logic [31:0]         perf_dbg_cnt,
    output logic [31:0]         perf_conflict_cnt
`endif
);

    arb_state_e        state_q;
    logic [3:0]        starve_q;
    logic [3:0]        starve_d;

    logic              if_win;
    logic              dbg_win;
    logic [ADDR_W-1:0] win_addr;
    logic              addr_err;

    logic              if_rsp_valid_q, if_rsp_valid_d;
    logic              if_rsp_err_q,   if_rsp_err_d;
    logic [DATA_W-1:0] if_rsp_inst_q,  if_rsp_inst_d;
    logic              dbg_rsp_valid_q, dbg_rsp_valid_d;
    logic              dbg_rsp_err_q,   dbg_rsp_err_d;
    logic [DATA_W-1:0] dbg_rsp_inst_q,  dbg_rsp_inst_d;

    // Pick the winner: DBG only when forced or IF is idle; nothing while reset is held
    always_comb begin
        if_win  = 1'b0;
        dbg_win = 1'b0;
        if (rst) begin
            if (bus.dbg_req && ((state_q == ARB_DBG_FORCE) || !bus.if_req)) begin
                dbg_win = 1'b1;
            end else if (bus.if_req) begin
                if_win = 1'b1;
            end
        end
    end

    assign win_addr = if_win  ? bus.if_addr  :
                      dbg_win ? bus.dbg_addr : '0;

    inst_addr_check #(
        .ADDR_W   (ADDR_W),
        .MEM_LOG2 (MEM_LOG2)
    ) u_addr_check (
        .addr_i (win_addr),
        .err_o  (addr_err)
    );

    assign bus.if_gnt   = if_win;
    assign bus.dbg_gnt  = dbg_win;
    assign bus.rom_addr = win_addr;
    assign bus.rom_ce   = ((if_win || dbg_win) && !addr_err) ? CHIP_ENABLE : CHIP_DISABLE;

    // Saturating increment so a long-denied DBG never wraps back to zero
    assign starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;

    // Arbitration FSM: count denied DBG cycles and force one DBG grant at the limit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ARB_IF_PRI;
            starve_q <= 4'd0;
        end else begin
            case (state_q)
                ARB_IF_PRI: begin
                    if (dbg_win) begin
                        starve_q <= 4'd0;
                    end else if (bus.dbg_req) begin
                        starve_q <= starve_d;
                        if (starve_d >= 4'(STARVE_LIMIT)) begin
                            state_q <= ARB_DBG_FORCE;
                        end
                    end
                end
                ARB_DBG_FORCE: begin
                    // Either DBG is granted this cycle or it withdrew; both end the forced window
                    starve_q <= 4'd0;
                    state_q  <= ARB_IF_PRI;
                end
                default: begin
                    starve_q <= 4'd0;
                    state_q  <= ARB_IF_PRI;
                end
            endcase
        end
    end

    // Next response values; errored fetches return zero, flush only masks IF valid/err
    always_comb begin
        if_rsp_valid_d  = if_win && !bus.if_flush;
        if_rsp_err_d    = if_win && !bus.if_flush && addr_err;
        if_rsp_inst_d   = if_rsp_inst_q;
        dbg_rsp_valid_d = dbg_win;
        dbg_rsp_err_d   = dbg_win && addr_err;
        dbg_rsp_inst_d  = dbg_rsp_inst_q;
        if (if_win) begin
            if_rsp_inst_d = addr_err ? DATA_W'(ZERO_WORD) : bus.rom_inst;
        end
        if (dbg_win) begin
            dbg_rsp_inst_d = addr_err ? DATA_W'(ZERO_WORD) : bus.rom_inst;
        end
    end

    // Register the ROM word so each grant returns exactly one cycle later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rsp_valid_q  <= 1'b0;
            if_rsp_err_q    <= 1'b0;
            if_rsp_inst_q   <= DATA_W'(ZERO_WORD);
            dbg_rsp_valid_q <= 1'b0;
            dbg_rsp_err_q   <= 1'b0;
            dbg_rsp_inst_q  <= DATA_W'(ZERO_WORD);
        end else begin
            if_rsp_valid_q  <= if_rsp_valid_d;
            if_rsp_err_q    <= if_rsp_err_d;
            if_rsp_inst_q   <= if_rsp_inst_d;
            dbg_rsp_valid_q <= dbg_rsp_valid_d;
            dbg_rsp_err_q   <= dbg_rsp_err_d;
            dbg_rsp_inst_q  <= dbg_rsp_inst_d;
        end
    end

    assign bus.if_rsp_valid  = if_rsp_valid_q;
    assign bus.if_rsp_err    = if_rsp_err_q;
    assign bus.if_rsp_inst   = if_rsp_inst_q;
    assign bus.dbg_rsp_valid = dbg_rsp_valid_q;
    assign bus.dbg_rsp_err   = dbg_rsp_err_q;
    assign bus.dbg_rsp_inst  = dbg_rsp_inst_q;

`ifdef INST_ROM_ARBITER_PERF_EN
    logic [31:0] perf_if_cnt_q;
    logic [31:0] perf_dbg_cnt_q;
    logic [31:0] perf_conflict_cnt_q;

    // Free-running event counters, wrapping naturally at 2^32
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_if_cnt_q       <= 32'd0;
            perf_dbg_cnt_q      <= 32'd0;
            perf_conflict_cnt_q <= 32'd0;
        end else begin
            if (if_win) begin
                perf_if_cnt_q <= perf_if_cnt_q + 32'd1;
            end
            if (dbg_win) begin
                perf_dbg_cnt_q <= perf_dbg_cnt_q + 32'd1;
            end
            if (bus.if_req && bus.dbg_req) begin
                perf_conflict_cnt_q <= perf_conflict_cnt_q + 32'd1;
            end
        end
    end

    assign perf_if_cnt       = perf_if_cnt_q;
    assign perf_dbg_cnt      = perf_dbg_cnt_q;
    assign perf_conflict_cnt = perf_conflict_cnt_q;
`endif

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// tb/tb_inst_rom_arbiter.sv - scoreboard bench for the instruction ROM arbiter
module tb_inst_rom_arbiter;
    import inst_rom_arbiter_pkg::*;

    typedef struct {
        int          cyc;
        logic [31:0] inst;
        logic        err;
    } rsp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    rsp_t if_q[$];
    rsp_t dbg_q[$];

    inst_rom_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef INST_ROM_ARBITER_PERF_EN
    logic [31:0] perf_if_cnt;
    logic [31:0] perf_dbg_cnt;
    logic [31:0] perf_conflict_cnt;
`endif

    inst_rom_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef INST_ROM_ARBITER_PERF_EN
        ,
        .perf_if_cnt       (perf_if_cnt),
        .perf_dbg_cnt      (perf_dbg_cnt),
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    // ROM model: word 2 holds a known instruction, every other word echoes its address
    assign bus.rom_inst = (bus.rom_addr == 32'h8) ? 32'h3401_1100 : {16'hBEEF, bus.rom_addr[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: match every presented response against the scoreboard queues
    always @(negedge clk) begin
        if (rst) begin
            if (bus.if_rsp_valid) begin
                if (if_q.size() == 0 || if_q[0].cyc != cyc) begin
                    chk("if_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    chk("if_rsp_inst", bus.if_rsp_inst, if_q[0].inst);
                    chk("if_rsp_err", {31'd0, bus.if_rsp_err}, {31'd0, if_q[0].err});
                    void'(if_q.pop_front());
                end
            end else if (if_q.size() != 0 && if_q[0].cyc == cyc) begin
                chk("if_missing_rsp", 32'd0, 32'd1);
                void'(if_q.pop_front());
            end
            if (bus.dbg_rsp_valid) begin
                if (dbg_q.size() == 0 || dbg_q[0].cyc != cyc) begin
                    chk("dbg_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    chk("dbg_rsp_inst", bus.dbg_rsp_inst, dbg_q[0].inst);
                    chk("dbg_rsp_err", {31'd0, bus.dbg_rsp_err}, {31'd0, dbg_q[0].err});
                    void'(dbg_q.pop_front());
                end
            end else if (dbg_q.size() != 0 && dbg_q[0].cyc == cyc) begin
                chk("dbg_missing_rsp", 32'd0, 32'd1);
                void'(dbg_q.pop_front());
            end
        end
    end

    task automatic drive(input logic ifr, input logic [31:0] ifa, input logic fl,
                         input logic dr, input logic [31:0] da);
        bus.if_req   = ifr;
        bus.if_addr  = ifa;
        bus.if_flush = fl;
        bus.dbg_req  = dr;
        bus.dbg_addr = da;
    endtask

    // One cycle of stimulus, grant/ROM checks, and the expected response queued for next cycle
    task automatic step(input logic ifr, input logic [31:0] ifa, input logic fl,
                        input logic dr, input logic [31:0] da,
                        input logic eig, input logic edg, input logic ece,
                        input logic [31:0] era, input logic [31:0] einst, input logic eerr);
        int   c;
        rsp_t r;
        @(posedge clk);
        #1;
        drive(ifr, ifa, fl, dr, da);
        c = cyc;
        @(negedge clk);
        chk("if_gnt", {31'd0, bus.if_gnt}, {31'd0, eig});
        chk("dbg_gnt", {31'd0, bus.dbg_gnt}, {31'd0, edg});
        chk("rom_ce", {31'd0, bus.rom_ce}, {31'd0, ece});
        chk("rom_addr", bus.rom_addr, era);
        r.cyc  = c + 1;
        r.inst = einst;
        r.err  = eerr;
        if (eig && !fl) if_q.push_back(r);
        if (edg) dbg_q.push_back(r);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        drive(0, 0, 0, 0, 0);
        #1;
        chk("reset_if_valid", {31'd0, bus.if_rsp_valid}, 32'd0);
        chk("reset_dbg_valid", {31'd0, bus.dbg_rsp_valid}, 32'd0);
        chk("reset_if_inst", bus.if_rsp_inst, 32'd0);
        chk("reset_dbg_inst", bus.dbg_rsp_inst, 32'd0);
        chk("reset_state", {31'd0, dut.state_q}, {31'd0, ARB_IF_PRI});
        chk("reset_starve", {28'd0, dut.starve_q}, 32'd0);
        #1;
        rst = 1'b1;

        idle();
        // IF only: word 2
        step(1, 32'h8, 0, 0, 0, 1, 0, 1, 32'h8, 32'h3401_1100, 0);
        idle();

        // Contention: IF wins four cycles, DBG forced on the fifth, IF resumes
        for (int i = 0; i < 4; i++) begin
            step(1, 32'h10 + 4*i, 0, 1, 32'h40, 1, 0, 1, 32'h10 + 4*i, 32'hBEEF_0010 + 4*i, 0);
        end
        step(1, 32'h20, 0, 1, 32'h40, 0, 1, 1, 32'h40, 32'hBEEF_0040, 0);
        step(1, 32'h20, 0, 0, 0, 1, 0, 1, 32'h20, 32'hBEEF_0020, 0);
        idle();

        // Misaligned DBG, out-of-range IF, and last legal word
        step(0, 0, 0, 1, 32'h6, 0, 1, 0, 32'h6, 32'h0, 1);
        step(1, 32'h8_0000, 0, 0, 0, 1, 0, 0, 32'h8_0000, 32'h0, 1);
        step(1, 32'h7_FFFC, 0, 0, 0, 1, 0, 1, 32'h7_FFFC, 32'hBEEF_FFFC, 0);
        idle();

        // Flush in grant cycle suppresses valid but inst still updates
        step(1, 32'h4, 1, 0, 0, 1, 0, 1, 32'h4, 32'hBEEF_0004, 0);
        idle();
        chk("flush_inst_updates", bus.if_rsp_inst, 32'hBEEF_0004);

        // Flush while a response is valid has no effect; flush never masks DBG
        step(1, 32'h8, 0, 0, 0, 1, 0, 1, 32'h8, 32'h3401_1100, 0);
        step(0, 0, 1, 1, 32'hC, 0, 1, 1, 32'hC, 32'hBEEF_000C, 0);
        idle();

        // DBG withdraws in the forced cycle: IF wins, count restarts from zero
        for (int i = 0; i < 4; i++) begin
            step(1, 32'h100 + 4*i, 0, 1, 32'h44, 1, 0, 1, 32'h100 + 4*i, 32'hBEEF_0100 + 4*i, 0);
        end
        step(1, 32'h200, 0, 0, 0, 1, 0, 1, 32'h200, 32'hBEEF_0200, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 32'h300 + 4*i, 0, 1, 32'h48, 1, 0, 1, 32'h300 + 4*i, 32'hBEEF_0300 + 4*i, 0);
        end
        step(1, 32'h400, 0, 1, 32'h48, 0, 1, 1, 32'h48, 32'hBEEF_0048, 0);
        idle();

        // Async reset while a response is valid, with starve count non-zero
        step(1, 32'h8, 0, 1, 32'h50, 1, 0, 1, 32'h8, 32'h3401_1100, 0);
        step(1, 32'h14, 0, 1, 32'h50, 1, 0, 1, 32'h14, 32'hBEEF_0014, 0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("pre_reset_valid", {31'd0, bus.if_rsp_valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk("async_reset_if_valid", {31'd0, bus.if_rsp_valid}, 32'd0);
        chk("async_reset_if_inst", bus.if_rsp_inst, 32'd0);
        chk("async_reset_state", {31'd0, dut.state_q}, {31'd0, ARB_IF_PRI});
        chk("async_reset_starve", {28'd0, dut.starve_q}, 32'd0);
        #1;
        rst = 1'b1;

        // Reset asserted after an IF request but before the edge: no grant, no response
        @(posedge clk);
        #1;
        drive(1, 32'h8, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("reset_no_if_gnt", {31'd0, bus.if_gnt}, 32'd0);
        chk("reset_no_rom_ce", {31'd0, bus.rom_ce}, 32'd0);
        @(posedge clk);
        #1;
        chk("reset_dropped_rsp", {31'd0, bus.if_rsp_valid}, 32'd0);
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        idle();
        idle();

        chk("if_queue_drained", if_q.size(), 32'd0);
        chk("dbg_queue_drained", dbg_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
